// File: rtl/button_conditioner_if.sv
// Bundle of raw push-button inputs and conditioned command outputs.
// The conditioner is the slave (it receives raw levels and drives pulses);
// the consumer side, game logic or a bench, takes the master view.
interface button_conditioner_if;
   logic       btn_c_i;
   logic       btn_u_i;
   logic       btn_d_i;
   logic       btn_r_i;
   logic       btn_l_i;
   logic       button_c_short;
   logic       button_c_long;
   logic       button_u;
   logic       button_d;
   logic       button_r;
   logic       button_l;
   logic [4:0] btn_level_o;

   modport master (
      output btn_c_i, btn_u_i, btn_d_i, btn_r_i, btn_l_i,
      input  button_c_short, button_c_long,
      input  button_u, button_d, button_r, button_l,
      input  btn_level_o
   );

   modport slave (
      input  btn_c_i, btn_u_i, btn_d_i, btn_r_i, btn_l_i,
      output button_c_short, button_c_long,
      output button_u, button_d, button_r, button_l,
      output btn_level_o
   );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser and debouncer for all five
// buttons, short/long press classification on centre, and press plus
// auto-repeat pulses on the four directional buttons.
// Button vector order everywhere is {c,u,d,r,l}: bit 4 = c ... bit 0 = l.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES      = 360000,
   parameter int LONG_PRESS_CYCLES    = 18000000,
   parameter int REPEAT_DELAY_CYCLES  = 18000000,
   parameter int REPEAT_PERIOD_CYCLES = 5400000
) (
   input logic                 clk,
   input logic                 rst,
   button_conditioner_if.slave bus
);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LP_W   = $clog2(LONG_PRESS_CYCLES + 1);
   localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PRESSED    = 2'd1;
   localparam logic [1:0] ST_LONG_FIRED = 2'd2;

   logic [4:0] raw;
   logic [4:0] sync1_q, sync1_d;
   logic [4:0] s_q, s_d;
   logic [4:0] stable_vec;
   logic [4:0] stable_dly_vec;
   logic [4:0] rise_vec;
   logic [3:0] dir_pulse_vec;

   assign raw = {bus.btn_c_i, bus.btn_u_i, bus.btn_d_i, bus.btn_r_i, bus.btn_l_i};

   // Two-stage synchroniser next-state
   always_comb begin
      sync1_d = raw;
      s_d     = sync1_q;
   end

   // Synchroniser flops
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         s_q     <= '0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
      end
   end

   // Per-button debounce and registered rising-edge detect
   for (genvar gi = 0; gi < 5; gi++) begin : g_db
      logic            stable_q, stable_d;
      logic            stable_dly_q, stable_dly_d;
      logic            rise_q, rise_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
      always_comb begin
         stable_d     = stable_q;
         cnt_d        = cnt_q;
         stable_dly_d = stable_q;
         rise_d       = stable_q & ~stable_dly_q;
         if (s_q[gi] == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = s_q[gi];
            cnt_d    = '0;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end

      // Debounce state flops
      always_ff @(posedge clk) begin
         if (rst) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            cnt_q        <= '0;
         end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
            cnt_q        <= cnt_d;
         end
      end

      assign stable_vec[gi]     = stable_q;
      assign stable_dly_vec[gi] = stable_dly_q;
      assign rise_vec[gi]       = rise_q;
   end

   // Directional press pulse and auto-repeat, one engine per direction
   for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      logic            active_q, active_d;
      logic            phase_q, phase_d;   // 0 = initial delay, 1 = periodic
      logic            pulse_q, pulse_d;
      logic [RP_W-1:0] cnt_q, cnt_d;

      // Pulse on press, then after the delay, then every period while held
      always_comb begin
         active_d = active_q;
         phase_d  = phase_q;
         cnt_d    = cnt_q;
         pulse_d  = 1'b0;
         if (rise_vec[gi]) begin
            pulse_d  = 1'b1;
            active_d = 1'b1;
            phase_d  = 1'b0;
            cnt_d    = '0;
         end else if (!stable_vec[gi]) begin
            active_d = 1'b0;
            phase_d  = 1'b0;
            cnt_d    = '0;
         end else if (active_q) begin
            if (!phase_q && cnt_q == RP_W'(REPEAT_DELAY_CYCLES - 1)) begin
               pulse_d = 1'b1;
               phase_d = 1'b1;
               cnt_d   = '0;
            end else if (phase_q && cnt_q == RP_W'(REPEAT_PERIOD_CYCLES - 1)) begin
               pulse_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + RP_W'(1);
            end
         end
      end

      // Repeat engine flops
      always_ff @(posedge clk) begin
         if (rst) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
         end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
         end
      end

      assign dir_pulse_vec[gi] = pulse_q;
   end

   // Centre button classification
   logic [1:0]      state_q, state_d;
   logic [LP_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            c_fall_q, c_fall_d;
   logic            c_short_q, c_short_d;
   logic            c_long_q, c_long_d;

   // Release is edge-detected with the same registered delay as the press,
   // so short pulses keep the fixed input-to-pulse latency. LONG_FIRED
   // leaves on the level so a release coinciding with the threshold is not lost.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      c_fall_d   = ~stable_vec[4] & stable_dly_vec[4];
      c_short_d  = 1'b0;
      c_long_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_vec[4]) begin
               state_d    = ST_PRESSED;
               hold_cnt_d = '0;
            end
         end
         ST_PRESSED: begin
            if (hold_cnt_q == LP_W'(LONG_PRESS_CYCLES - 1)) begin
               c_long_d = 1'b1;
               state_d  = ST_LONG_FIRED;
            end else if (c_fall_q) begin
               c_short_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + LP_W'(1);
            end
         end
         ST_LONG_FIRED: begin
            if (!stable_vec[4]) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Centre FSM flops and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         c_fall_q   <= 1'b0;
         c_short_q  <= 1'b0;
         c_long_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         c_fall_q   <= c_fall_d;
         c_short_q  <= c_short_d;
         c_long_q   <= c_long_d;
      end
   end

   assign bus.button_c_short = c_short_q;
   assign bus.button_c_long  = c_long_q;
   assign bus.button_u       = dir_pulse_vec[3];
   assign bus.button_d       = dir_pulse_vec[2];
   assign bus.button_r       = dir_pulse_vec[1];
   assign bus.button_l       = dir_pulse_vec[0];
   assign bus.btn_level_o    = stable_vec;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Expected pulses (cycle, output id) are queued as stimulus is applied and
// matched in order by a monitor that samples on the falling edge.
`timescale 1ns/1ps
module tb_button_conditioner;
   localparam int DB = 4;
   localparam int LP = 20;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam int LAT = DB + 3;   // raw sample edge -> pulse

   // output ids: 0 c_short, 1 c_long, 2 u, 3 d, 4 r, 5 l
   typedef struct {
      int cyc;
      int id;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   e0;
   ev_t  exp_q[$];

   button_conditioner_if bus();

   button_conditioner #(
      .DEBOUNCE_CYCLES      (DB),
      .LONG_PRESS_CYCLES    (LP),
      .REPEAT_DELAY_CYCLES  (RD),
      .REPEAT_PERIOD_CYCLES (RP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input int id);
      ev_t e;
      e.cyc = c;
      e.id  = id;
      exp_q.push_back(e);
   endtask

   // Match every observed pulse against the head of the expectation queue
   always @(negedge clk) begin
      logic [5:0] p;
      ev_t        e;
      p = {bus.button_l, bus.button_r, bus.button_d,
           bus.button_u, bus.button_c_long, bus.button_c_short};
      for (int i = 0; i < 6; i++) begin
         if (p[i] === 1'b1) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
            end else begin
               e.cyc = -1;
               e.id  = -1;
            end
            $display("pulse id=%0d at cycle %0d (expected id=%0d cycle %0d)", i, cyc, e.id, e.cyc);
            check("pulse_id", i, e.id);
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic check_all_low(input string tag);
      check({tag, "_c_short"}, bus.button_c_short, 0);
      check({tag, "_c_long"}, bus.button_c_long, 0);
      check({tag, "_u"}, bus.button_u, 0);
      check({tag, "_d"}, bus.button_d, 0);
      check({tag, "_r"}, bus.button_r, 0);
      check({tag, "_l"}, bus.button_l, 0);
      check({tag, "_level"}, bus.btn_level_o, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.btn_c_i = 1'b0;
      bus.btn_u_i = 1'b0;
      bus.btn_d_i = 1'b0;
      bus.btn_r_i = 1'b0;
      bus.btn_l_i = 1'b0;
      tick(3);
      check_all_low("reset");
      rst = 1'b0;
      tick(3);

      // 1. bounce on up, then a clean hold
      for (int k = 0; k < 20; k++) begin
         bus.btn_u_i = ((k / 2) % 2) == 0;
         tick(1);
      end
      e0 = cyc + 1;
      push(e0 + LAT, 2);
      bus.btn_u_i = 1'b1;
      tick(7);
      check("bounce_level", bus.btn_level_o, 5'b01000);
      tick(2);
      bus.btn_u_i = 1'b0;
      tick(25);
      check("bounce_missed", exp_q.size(), 0);

      // 2. short centre press
      e0 = cyc + 1;
      bus.btn_c_i = 1'b1;
      tick(12);
      bus.btn_c_i = 1'b0;
      push(e0 + 12 + LAT, 0);
      tick(30);
      check("short_missed", exp_q.size(), 0);

      // 3. long centre press, no short on release
      e0 = cyc + 1;
      bus.btn_c_i = 1'b1;
      push(e0 + LAT + LP, 1);
      tick(40);
      bus.btn_c_i = 1'b0;
      tick(30);
      check("long_missed", exp_q.size(), 0);

      // 4. auto-repeat on right
      e0 = cyc + 1;
      bus.btn_r_i = 1'b1;
      push(e0 + LAT, 4);
      for (int off = RD; off <= 35; off += RP) push(e0 + LAT + off, 4);
      tick(40);
      bus.btn_r_i = 1'b0;
      tick(30);
      check("repeat_missed", exp_q.size(), 0);

      // 5. reset in the middle of a centre hold
      e0 = cyc + 1;
      bus.btn_c_i = 1'b1;
      tick(14);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_all_low("midreset");
      e0 = cyc + 1;
      push(e0 + LAT + LP, 1);
      tick(40);
      bus.btn_c_i = 1'b0;
      tick(30);
      check("midreset_missed", exp_q.size(), 0);

      // 6. up and left together
      e0 = cyc + 1;
      bus.btn_u_i = 1'b1;
      bus.btn_l_i = 1'b1;
      push(e0 + LAT, 2);
      push(e0 + LAT, 5);
      tick(8);
      check("simul_level", bus.btn_level_o, 5'b01001);
      bus.btn_u_i = 1'b0;
      bus.btn_l_i = 1'b0;
      tick(30);
      check("simul_missed", exp_q.size(), 0);

      // 7. down held just past the first repeat
      e0 = cyc + 1;
      bus.btn_d_i = 1'b1;
      push(e0 + LAT, 3);
      push(e0 + LAT + RD, 3);
      tick(14);
      bus.btn_d_i = 1'b0;
      tick(30);
      check("down_missed", exp_q.size(), 0);
      check("final_level", bus.btn_level_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
